// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider with registered rise/fall tick strobes.
// Define CLKDIV_PHASE_SYNC_EN to add the sync_req input that phase-aligns all running channels.
module clk_div_prog #(
  parameter int CH          = 2,
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 750
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         en,
  input  logic [CH*CNT_W-1:0]   div_in,
  input  logic [CH-1:0]         div_load,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic                  sync_req,
`endif
  output logic [CH-1:0]         div_pend,
  output logic [CH-1:0]         clkout,
  output logic [CH-1:0]         tick_rise,
  output logic [CH-1:0]         tick_fall
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

  logic sync;
`ifdef CLKDIV_PHASE_SYNC_EN
  assign sync = sync_req;
`else
  assign sync = 1'b0;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] div_new;
    logic             pend_q;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             boundary;

    assign div_new  = div_in[i*CNT_W +: CNT_W];
    assign boundary = (cnt == div_act);

    // NOTE: every register here is assigned with <= so all channel state updates
    // from the same pre-edge values; blocking writes would leak new values into later tests.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt      <= '0;
        div_act  <= DIV_RST;
        pend_val <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else if (!en[i] || sync) begin
        // Idle and phase sync both park the channel at the start of a low half-period,
        // so a divisor change here cannot glitch; apply it immediately.
        cnt    <= '0;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (div_load[i]) begin
          div_act <= div_new;
          pend_q  <= 1'b0;
        end else if (pend_q) begin
          div_act <= pend_val;
          pend_q  <= 1'b0;
        end
      end else if (boundary) begin
        cnt    <= '0;
        clk_q  <= ~clk_q;
        rise_q <= ~clk_q;
        fall_q <= clk_q;
        // A load in the boundary cycle governs the half-period starting now.
        if (div_load[i]) begin
          div_act <= div_new;
          pend_q  <= 1'b0;
        end else if (pend_q) begin
          div_act <= pend_val;
          pend_q  <= 1'b0;
        end
      end else begin
        cnt    <= cnt + CNT_W'(1);
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (div_load[i]) begin
          pend_val <= div_new;
          pend_q   <= 1'b1;
        end
      end
    end

    assign div_pend[i]  = pend_q;
    assign clkout[i]    = clk_q;
    assign tick_rise[i] = rise_q;
    assign tick_fall[i] = fall_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: expected tick edges are queued per channel
// when stimulus is applied and compared as the DUT emits tick_rise/tick_fall.
module tb_clk_div_prog;

  localparam int CH          = 2;
  localparam int CNT_W       = 16;
  localparam int DIV_DEFAULT = 750;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH-1:0]        en;
  logic [CH*CNT_W-1:0]  div_in;
  logic [CH-1:0]        div_load;
  logic [CH-1:0]        div_pend;
  logic [CH-1:0]        clkout;
  logic [CH-1:0]        tick_rise;
  logic [CH-1:0]        tick_fall;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic                 sync_req;
`endif

  clk_div_prog #(.CH(CH), .CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_load  (div_load),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync_req  (sync_req),
`endif
    .div_pend  (div_pend),
    .clkout    (clkout),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the index of the posedge just before it.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int at; bit rise; } ev_t;
  ev_t q0[$];
  ev_t q1[$];

  task automatic push_ev(input int ch, input int at, input bit rise);
    ev_t e;
    e.at   = at;
    e.rise = rise;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic expect_edges(input int ch, input int first, input int half,
                              input int n, input bit first_rise);
    for (int k = 0; k < n; k++)
      push_ev(ch, first + k * half, (k % 2 == 0) ? first_rise : !first_rise);
  endtask

  // Scoreboard: each observed tick must match the head of its channel's queue.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (tick_rise[c] || tick_fall[c]) begin
        ev_t e;
        e.at   = -1;
        e.rise = 1'b0;
        if (c == 0 && q0.size() > 0)      e = q0.pop_front();
        else if (c == 1 && q1.size() > 0) e = q1.pop_front();
        check($sformatf("ch%0d edge cycle", c), cyc, e.at);
        check($sformatf("ch%0d tick_rise", c), tick_rise[c], e.rise);
        check($sformatf("ch%0d clkout after tick", c), clkout[c], e.rise);
        check($sformatf("ch%0d both ticks", c), tick_rise[c] & tick_fall[c], 0);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_div(input int ch, input int val);
    div_in[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = '0;
    div_load = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_load(input int ch, input int val);
    set_div(ch, val);
    div_load[ch] = 1'b1;
    @(negedge clk);
    div_load = '0;
    check($sformatf("ch%0d idle load pend", ch), div_pend[ch], 0);
  endtask

  task automatic pulse_load(input int ch, input int val);
    set_div(ch, val);
    div_load[ch] = 1'b1;
    @(negedge clk);
    div_load = '0;
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    @(negedge clk);
    check({tag, " ch0 missing edges"}, q0.size(), 0);
    check({tag, " ch1 missing edges"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  typedef struct { int ch; bit load; int div; int half; int n; } vec_t;
  vec_t vecs[5];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int c0;
    vecs[0] = '{0, 1'b0, 0, 751, 3};
    vecs[1] = '{1, 1'b1, 9, 10, 4};
    vecs[2] = '{0, 1'b1, 0, 1, 6};
    vecs[3] = '{1, 1'b1, 1, 2, 5};
    vecs[4] = '{0, 1'b1, 4, 5, 4};

    rst = 1'b1; en = '0; div_load = '0; div_in = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    sync_req = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("reset clkout", clkout, 0);
    check("reset tick_rise", tick_rise, 0);
    check("reset tick_fall", tick_fall, 0);
    check("reset div_pend", div_pend, 0);
    rst = 1'b0;

    // Table-driven: steady divide ratios, including the reset default.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      if (vecs[i].load) idle_load(vecs[i].ch, vecs[i].div);
      c0 = cyc;
      en[vecs[i].ch] = 1'b1;
      expect_edges(vecs[i].ch, c0 + vecs[i].half, vecs[i].half, vecs[i].n, 1'b1);
      wait_until(c0 + vecs[i].n * vecs[i].half);
      en = '0;
      drain($sformatf("vec%0d", i));
    end

    // Div 9, load 3 at cnt=4: current half stays 10, then halves of 4.
    do_reset();
    idle_load(0, 9);
    c0 = cyc;
    en[0] = 1'b1;
    expect_edges(0, c0 + 10, 10, 1, 1'b1);
    expect_edges(0, c0 + 14, 4, 3, 1'b0);
    wait_until(c0 + 4);
    pulse_load(0, 3);
    check("s2 pend after load", div_pend[0], 1);
    wait_until(c0 + 9);
    check("s2 pend before boundary", div_pend[0], 1);
    wait_until(c0 + 10);
    check("s2 pend at boundary", div_pend[0], 0);
    wait_until(c0 + 22);
    en = '0;
    drain("s2");

    // Two loads before one boundary: last value (2) wins.
    do_reset();
    idle_load(0, 9);
    c0 = cyc;
    en[0] = 1'b1;
    expect_edges(0, c0 + 10, 10, 1, 1'b1);
    expect_edges(0, c0 + 13, 3, 3, 1'b0);
    wait_until(c0 + 2);
    pulse_load(0, 5);
    check("s3 pend first load", div_pend[0], 1);
    wait_until(c0 + 5);
    pulse_load(0, 2);
    wait_until(c0 + 9);
    check("s3 pend before boundary", div_pend[0], 1);
    wait_until(c0 + 10);
    check("s3 pend at boundary", div_pend[0], 0);
    wait_until(c0 + 19);
    en = '0;
    drain("s3");

    // Load 0 in a boundary cycle: bypasses pend, next half-period is 1 cycle.
    do_reset();
    idle_load(0, 4);
    c0 = cyc;
    en[0] = 1'b1;
    expect_edges(0, c0 + 5, 5, 1, 1'b1);
    expect_edges(0, c0 + 6, 1, 3, 1'b0);
    wait_until(c0 + 4);
    pulse_load(0, 0);
    check("s4 pend boundary load", div_pend[0], 0);
    @(negedge clk);
    check("s4 pend after boundary", div_pend[0], 0);
    wait_until(c0 + 8);
    en = '0;
    drain("s4");

    // ch0 disabled while high (no tick_fall), ch1 keeps running, ch0 re-enabled.
    do_reset();
    set_div(0, 4);
    set_div(1, 2);
    div_load = 2'b11;
    @(negedge clk);
    div_load = '0;
    c0 = cyc;
    en = 2'b11;
    expect_edges(1, c0 + 3, 3, 6, 1'b1);
    expect_edges(0, c0 + 5, 5, 1, 1'b1);
    expect_edges(0, c0 + 14, 5, 2, 1'b1);
    wait_until(c0 + 6);
    check("s5 ch0 high before drop", clkout[0], 1);
    en[0] = 1'b0;
    @(negedge clk);
    check("s5 ch0 clkout after drop", clkout[0], 0);
    check("s5 ch0 no tick_fall", tick_fall[0], 0);
    check("s5 ch1 clkout level", clkout[1], 0);
    wait_until(c0 + 9);
    en[0] = 1'b1;
    wait_until(c0 + 19);
    en = '0;
    drain("s5");

    // Reset mid-period with a pending divisor: pending is discarded, default restored.
    do_reset();
    idle_load(0, 9);
    c0 = cyc;
    en[0] = 1'b1;
    wait_until(c0 + 4);
    pulse_load(0, 3);
    check("s7 pend before reset", div_pend[0], 1);
    wait_until(c0 + 6);
    rst = 1'b1;
    @(negedge clk);
    check("s7 pend after reset", div_pend[0], 0);
    check("s7 clkout after reset", clkout[0], 0);
    rst = 1'b0;
    expect_edges(0, c0 + 7 + 751, 751, 1, 1'b1);
    wait_until(c0 + 758);
    en = '0;
    drain("s7");

`ifdef CLKDIV_PHASE_SYNC_EN
    // Phase sync realigns both channels; reset mid-period clears everything.
    do_reset();
    set_div(0, 3);
    set_div(1, 7);
    div_load = 2'b11;
    @(negedge clk);
    div_load = '0;
    c0 = cyc;
    en = 2'b11;
    expect_edges(0, c0 + 4, 4, 2, 1'b1);
    expect_edges(1, c0 + 8, 8, 1, 1'b1);
    expect_edges(0, c0 + 14, 4, 3, 1'b1);
    expect_edges(1, c0 + 18, 8, 1, 1'b1);
    wait_until(c0 + 9);
    sync_req = 1'b1;
    @(negedge clk);
    sync_req = 1'b0;
    check("sync clkout", clkout, 0);
    check("sync tick_fall", tick_fall, 0);
    wait_until(c0 + 23);
    rst = 1'b1;
    @(negedge clk);
    check("sync rst clkout", clkout, 0);
    check("sync rst ticks", tick_rise | tick_fall, 0);
    check("sync rst pend", div_pend, 0);
    rst = 1'b0;
    en  = '0;
    drain("sync");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel, runtime-programmable clock-enable/clock divider.
- Generalised successor of the team's fixed 66.67 kHz divider. Serves PmodJSTK SPI timing, UART/PS2 sampling and game-tick generation from one block.
- Each channel has its own half-period divisor, enable, and rise/fall tick strobes.
- Divisor changes are glitch-free: they take effect only at a half-period boundary.

Parameters:
- CH, 2: number of independent channels.
- CNT_W, 16: counter/divisor width per channel.
- DIV_DEFAULT, 750: reset divisor for every channel. Half-period = DIV+1 clk cycles, so 750 at 100 MHz gives ≈66.6 kHz.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  CH  per-channel run enable.
- div_in  in  CH*CNT_W  packed divisors; channel i uses bits [i*CNT_W +: CNT_W].
- div_load  in  CH  one-cycle strobe; captures that channel's div_in.
- div_pend  out  CH  high while a loaded divisor is not yet applied.
- clkout  out  CH  divided clock, registered, 50% duty.
- tick_rise  out  CH  one-cycle pulse, asserted in the same cycle clkout becomes 1.
- tick_fall  out  CH  one-cycle pulse, asserted in the same cycle clkout becomes 0.

Behaviour:
- Per-channel registers: cnt[CNT_W], div_act, pend_val, pend, clkout, tick_rise, tick_fall. All outputs are registered.
- Reset (rst=1 at posedge): cnt=0, div_act=DIV_DEFAULT, pend=0, clkout=0, ticks=0 on all channels. Reset overrides all other inputs, including mid-period; any pending divisor is discarded.
- en=0 (idle):
  - cnt<=0, clkout<=0, ticks<=0.
  - If clkout was 1 when en fell, no tick_fall is issued.
  - div_load while idle writes div_act directly on the next cycle; div_pend stays 0.
- en=1, cnt!=div_act: cnt<=cnt+1; clkout holds; ticks 0.
- en=1, cnt==div_act (boundary):
  - cnt<=0 and clkout<=~clkout.
  - tick_rise<=~clkout; tick_fall<=clkout.
  - If pend=1: div_act<=pend_val and pend<=0.
- div_load while running, non-boundary cycle: pend_val<=div_in slice, pend<=1. A second load before the boundary overwrites pend_val; last value wins.
- div_load in a boundary cycle: the new div_in value is written straight to div_act, bypassing and clearing pend. It governs the half-period that starts next.
- Divisor 0: clkout toggles every cycle (clk/2); ticks alternate every cycle.
- Divisor all-ones: half-period = 2^CNT_W cycles. cnt never exceeds div_act, so there is no overflow.
- Because div_act changes only when cnt=0, cnt>div_act cannot occur.
- Enable-to-first-edge latency: with en rising at cycle 0 from idle, clkout first rises at cycle div_act+1 after en is sampled high.
- Channels are fully independent. No cross-channel state except the optional sync.

Optional Feature:
- Macro CLKDIV_PHASE_SYNC_EN.
- Defined:
  - Adds input sync_req (1 bit).
  - A sync_req pulse forces, for every channel with en=1: cnt<=0, clkout<=0, no ticks.
  - Any pending divisor is applied immediately (div_act<=pend_val, pend<=0).
  - Channels restart phase-aligned.
  - rst has priority over sync_req; sync_req has priority over the boundary/load rules. A div_load in the same cycle as sync_req lands in div_act.
- Undefined: the port is absent and channels free-run.

Test Plan:
- Reset, en=1, DIV_DEFAULT=750 -> clkout first rises at cycle 751 and toggles every 751 cycles; tick_rise/tick_fall are single-cycle, each in the toggle cycle. Period = 1502 clk.
- Running with div 9, load 3 at cnt=4 -> div_pend=1 until the boundary. Current half-period still lasts 10 cycles; subsequent half-periods last 4; div_pend drops at that boundary.
- Load 5 then 2 before one boundary -> only 2 is applied; half-periods of 3 cycles afterwards.
- Load 0 exactly in a boundary cycle -> next half-period is 1 cycle, and div_pend never asserts.
- en dropped while clkout=1, ch1 left running -> ch0 clkout=0 next cycle with no tick_fall; ch1 unaffected. Re-enable -> rise after div+1 cycles.
- (CLKDIV_PHASE_SYNC_EN) ch0 div 3, ch1 div 7, sync_req pulse -> both clkout=0, cnt=0; both rise at 4 and 8 cycles after sync. rst asserted mid-period -> all outputs return to reset values the next cycle.
